gpioemu_mulseq: RTL and testbench

//  Bus-mapped sequential multiplier peripheral; parametrised successor of the gpioemu multiplier.

---
 rtl/gpioemu_pkg.sv | 15 +
 rtl/gpioemu_mul_core.sv | 63 ++++++
 rtl/gpioemu_mulseq.sv | 88 ++++++++
 tb/tb_gpioemu_mulseq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpioemu_pkg.sv
// gpioemu_pkg: shared address map, status/control bit positions and engine states.
package gpioemu_pkg;
    localparam logic [15:0] DEF_ADDR_A    = 16'h037F;
    localparam logic [15:0] DEF_ADDR_B    = 16'h0388;
    localparam logic [15:0] DEF_ADDR_RES  = 16'h0390;
    localparam logic [15:0] DEF_ADDR_STAT = 16'h0398;
    localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] DEF_ADDR_CNT  = 16'h03A8;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_OVF   = 2;
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} mul_state_e;
endpackage

// File: rtl/gpioemu_mul_core.sv
// gpioemu_mul_core: fixed-latency shift-add multiplier, one multiplier bit per cycle.
module gpioemu_mul_core
    import gpioemu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH + 1);
    mul_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, ash_q, ash_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      i_q, i_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ash_q   <= '0;
            b_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ash_q   <= ash_d;
            b_q     <= b_d;
            i_q     <= i_d;
        end
    end
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ash_d   = ash_q;
        b_d     = b_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_RUN;
                acc_d   = '0;
                ash_d   = (2*WIDTH)'(a_i);
                b_d     = b_i;
                i_d     = '0;
            end
            S_RUN: begin
                acc_d   = b_q[0] ? acc_q + ash_q : acc_q;
                ash_d   = ash_q << 1;
                b_d     = b_q >> 1;
                i_d     = i_q + 1'b1;
                state_d = (i_q == CW'(WIDTH - 1)) ? S_FINISH : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end
    assign busy_o = state_q != S_IDLE;
    assign done_o = state_q == S_FINISH;
    assign prod_o = acc_q;
endmodule

// File: rtl/gpioemu_mulseq.sv
// gpioemu_mulseq: bus-mapped sequential multiplier with op counter mirrored on gpio_out.
module gpioemu_mulseq
    import gpioemu_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [15:0] ADDR_A    = DEF_ADDR_A,
    parameter logic [15:0] ADDR_B    = DEF_ADDR_B,
    parameter logic [15:0] ADDR_RES  = DEF_ADDR_RES,
    parameter logic [15:0] ADDR_STAT = DEF_ADDR_STAT,
    parameter logic [15:0] ADDR_CTRL = DEF_ADDR_CTRL,
    parameter logic [15:0] ADDR_CNT  = DEF_ADDR_CNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);
    logic               swr_q, srd_q, done_q, ovf_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [31:0]        cnt_q, rdata_q, ins_q, stat, rd_data;
    logic               busy, fin, wr_ev, rd_ev, start, clr;
    logic [2*WIDTH-1:0] prod;
    assign wr_ev = swr & ~swr_q;
    assign rd_ev = srd & ~srd_q;
    assign start = wr_ev && saddress == ADDR_CTRL && sdata_in[CTRL_START] && !busy;
    assign clr   = wr_ev && saddress == ADDR_CTRL && sdata_in[CTRL_CLR];
    gpioemu_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .start_i(start),
        .a_i    (a_q),
        .b_i    (b_q),
        .busy_o (busy),
        .done_o (fin),
        .prod_o (prod)
    );
    always_comb begin
        stat            = '0;
        stat[STAT_BUSY] = busy;
        stat[STAT_DONE] = done_q;
        stat[STAT_OVF]  = ovf_q;
        rd_data = (saddress == ADDR_RES)  ? 32'(res_q) :
                  (saddress == ADDR_STAT) ? stat :
                  (saddress == ADDR_CNT)  ? cnt_q : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ins_q   <= '0;
        end else begin
            swr_q <= swr;
            srd_q <= srd;
            if (wr_ev && !busy && saddress == ADDR_A) a_q <= sdata_in[WIDTH-1:0];
            if (wr_ev && !busy && saddress == ADDR_B) b_q <= sdata_in[WIDTH-1:0];
            if (start) begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (fin) begin
                res_q  <= prod[WIDTH-1:0];
                ovf_q  <= |prod[2*WIDTH-1:WIDTH];
                done_q <= 1'b1;
            end
            // a clear landing on the finish cycle takes priority over the increment
            cnt_q <= clr ? '0 : fin ? cnt_q + 1'b1 : cnt_q;
            if (rd_ev) rdata_q <= rd_data;
            if (gpio_latch) ins_q <= gpio_in;
        end
    end
    assign sdata_out      = rdata_q;
    assign gpio_out       = cnt_q;
    assign gpio_in_s_insp = ins_q;
endmodule

// File: tb/tb_gpioemu_mulseq.sv
// tb_gpioemu_mulseq: vector table, directed corner sequences and random ops vs. arithmetic model.
module tb_gpioemu_mulseq;
    localparam int W = 32;
    localparam logic [15:0] A_A = 16'h037F, A_B = 16'h0388, A_RES = 16'h0390;
    localparam logic [15:0] A_STAT = 16'h0398, A_CTRL = 16'h03A0, A_CNT = 16'h03A8;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;
    logic        clk = 1'b0, reset = 1'b1, srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
    logic [15:0] saddress = '0;
    logic [31:0] sdata_in = '0, gpio_in = '0;
    logic [31:0] sdata_out, gpio_out, gpio_in_s_insp;
    logic [31:0] cnt_m = '0, res_m = '0, rd, held;
    logic [63:0] p;
    int          n_cmp = 0, n_fail = 0;
    vec_t        vecs[8];

    gpioemu_mulseq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .saddress      (saddress),
        .srd           (srd),
        .swr           (swr),
        .sdata_in      (sdata_in),
        .sdata_out     (sdata_out),
        .gpio_in       (gpio_in),
        .gpio_latch    (gpio_latch),
        .gpio_out      (gpio_out),
        .gpio_in_s_insp(gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        saddress = addr;
        sdata_in = data;
        swr      = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        saddress = addr;
        srd      = 1'b1;
        @(negedge clk);
        srd  = 1'b0;
        data = sdata_out;
    endtask

    task automatic wait_cnt(input logic [31:0] target);
        int k = 0;
        while (gpio_out !== target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_cnt", gpio_out, target);
    endtask

    // Full operation; also pins the start-to-done latency via gpio_out.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ovf, input string nm);
        bus_write(A_A, a);
        bus_write(A_B, b);
        bus_write(A_CTRL, 32'h1);
        repeat (W) @(negedge clk);
        check({nm, "_cnt_before_done"}, gpio_out, cnt_m);
        cnt_m++;
        @(negedge clk);
        check({nm, "_cnt_at_done"}, gpio_out, cnt_m);
        res_m = res;
        bus_read(A_RES, rd);
        check({nm, "_res"}, rd, res);
        bus_read(A_STAT, rd);
        check({nm, "_stat"}, rd, {29'b0, ovf, 2'b10});
        bus_read(A_CNT, rd);
        check({nm, "_cnt"}, rd, cnt_m);
    endtask

    initial begin
        vecs[0] = '{32'h2,        32'h8,        32'h10,       1'b0};
        vecs[1] = '{32'h10,       32'h80,       32'h800,      1'b0};
        vecs[2] = '{32'h80000,    32'h8007,     32'h00380000, 1'b1};
        vecs[3] = '{32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b1};
        vecs[5] = '{32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{32'h10000,    32'h10000,    32'h0,        1'b1};
        vecs[7] = '{32'hFFFF,     32'hFFFF,     32'hFFFE0001, 1'b0};

        #2;
        check("rst_sdata_out", sdata_out, 0);
        check("rst_gpio_out", gpio_out, 0);
        check("rst_insp", gpio_in_s_insp, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(A_STAT, rd);
        check("rst_stat", rd, 0);
        bus_read(A_RES, rd);
        check("rst_res", rd, 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, $sformatf("vec%0d", i));

        // writes and start while busy are ignored; RES holds previous result
        bus_write(A_A, 32'd3);
        bus_write(A_B, 32'd7);
        bus_write(A_CTRL, 32'h1);
        cnt_m++;
        bus_write(A_A, 32'd5);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STAT, rd);
        check("busy_stat", rd, 32'h1);
        bus_read(A_RES, rd);
        check("res_while_busy", rd, res_m);
        wait_cnt(cnt_m);
        repeat (3) @(negedge clk);
        check("no_second_op", gpio_out, cnt_m);
        bus_read(A_RES, rd);
        check("busy_res", rd, 32'd21);
        bus_write(A_CTRL, 32'h1);
        cnt_m++;
        wait_cnt(cnt_m);
        bus_read(A_RES, rd);
        check("a_kept_after_busy_write", rd, 32'd21);

        // asynchronous reset mid-operation
        bus_write(A_A, 32'd9);
        bus_write(A_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_sdata_out", sdata_out, 0);
        check("abort_gpio_out", gpio_out, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt_m = 0;
        res_m = 0;
        repeat (W + 5) @(negedge clk);
        check("abort_no_done", gpio_out, 0);
        bus_read(A_STAT, rd);
        check("abort_stat", rd, 0);
        bus_read(A_RES, rd);
        check("abort_res", rd, 0);
        bus_read(A_CNT, rd);
        check("abort_cnt", rd, 0);
        run_op(32'd6, 32'd7, 32'd42, 1'b0, "post_reset");

        // swr held well past one full operation starts exactly one op
        @(negedge clk);
        saddress = A_CTRL;
        sdata_in = 32'h1;
        swr      = 1'b1;
        repeat (W + 12) @(negedge clk);
        swr = 1'b0;
        cnt_m++;
        repeat (W + 6) @(negedge clk);
        check("held_swr_once", gpio_out, cnt_m);

        // counter clear lands on the finish cycle
        bus_write(A_CTRL, 32'h1);
        repeat (W) @(negedge clk);
        saddress = A_CTRL;
        sdata_in = 32'h2;
        swr      = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        check("clr_on_finish", gpio_out, 0);
        cnt_m = 0;
        bus_read(A_STAT, rd);
        check("clr_finish_stat", rd, 32'h2);
        bus_read(A_STAT, rd);
        check("done_sticky", rd, 32'h2);
        run_op(32'd100, 32'd100, 32'd10000, 1'b0, "after_clr");

        // gpio capture
        check("insp_before_latch", gpio_in_s_insp, 0);
        @(negedge clk);
        gpio_in    = 32'hA5A5A5A5;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in    = 32'h12345678;
        repeat (3) @(negedge clk);
        check("insp_held", gpio_in_s_insp, 32'hA5A5A5A5);

        // unmapped read and read-data hold
        bus_read(16'h1234, rd);
        check("unmapped_read", rd, 0);
        bus_read(A_CNT, rd);
        check("cnt_read", rd, cnt_m);
        held = rd;
        bus_write(A_CTRL, 32'h1);
        cnt_m++;
        wait_cnt(cnt_m);
        check("read_hold", sdata_out, held);

        // random operations against plain 64-bit arithmetic
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            p = 64'(a) * 64'(b);
            run_op(a, b, p[31:0], |p[63:32], $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
